round_referee: RTL and testbench

//   Referee FSM that sequences each tug-of-war round: random hold-off, GO lamp, first-press arbitration.

---
 rtl/round_referee.sv | 202 ++++++++++++++++++++
 tb/tb_round_referee.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/round_referee.sv
// Tug-of-war round referee: random hold-off, GO lamp, first-press arbitration.
// Ports: clk, rst (async active-low), btn_l/btn_r (raw), start, over -> rw, wingame, go_led, foul, state[2:0].
// Build option: TIE_BREAK_EN awards GO-state ties by a toggling priority flag.
module round_referee #(
  parameter int          TICK_DIV  = 50000,
  parameter int          MIN_TICKS = 500,
  parameter int          RAND_BITS = 11,
  parameter int          HOLD_CYC  = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_l,
  input  logic       btn_r,
  input  logic       start,
  input  logic       over,
  output logic       rw,
  output logic       wingame,
  output logic       go_led,
  output logic       foul,
  output logic [2:0] state
);

  localparam int DLY_A = RAND_BITS + 1;
  localparam int DLY_B = $clog2(MIN_TICKS + (1 << RAND_BITS));
  localparam int DLY_W = (DLY_A > DLY_B) ? DLY_A : DLY_B;
  localparam int PRE_W = $clog2(TICK_DIV);
  localparam int HLD_W = $clog2(HOLD_CYC);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_GO      = 3'd2,
    S_RESULT  = 3'd3,
    S_RELEASE = 3'd4,
    S_DONE    = 3'd5
  } st_t;

  st_t              st;
  logic [15:0]      lfsr;
  logic             lfsr_fb;
  logic [PRE_W-1:0] presc;
  logic             tick;
  logic [DLY_W-1:0] dly;
  logic [DLY_W-1:0] dly_seed;
  logic [HLD_W-1:0] hold;
  logic             ovr_pend;
  logic [1:0]       sync_l;
  logic [1:0]       sync_r;
  logic             bl;
  logic             br;
  logic             both;
  logic             only_l;
  logic             only_r;
`ifdef TIE_BREAK_EN
  logic             tie_flag;
`endif

  assign state   = st;
  assign bl      = sync_l[1];
  assign br      = sync_r[1];
  assign both    = bl & br;
  assign only_l  = bl & ~br;
  assign only_r  = br & ~bl;
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign tick    = (presc == PRE_W'(TICK_DIV - 1));
  assign dly_seed = DLY_W'(MIN_TICKS)
                  + {{(DLY_W - RAND_BITS){1'b0}}, lfsr[RAND_BITS-1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_l <= '0;
      sync_r <= '0;
    end else begin
      sync_l <= {sync_l[0], btn_l};
      sync_r <= {sync_r[0], btn_r};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st       <= S_IDLE;
      lfsr     <= LFSR_SEED;
      presc    <= '0;
      dly      <= '0;
      hold     <= '0;
      ovr_pend <= 1'b0;
      rw       <= 1'b0;
      wingame  <= 1'b0;
      go_led   <= 1'b0;
      foul     <= 1'b0;
`ifdef TIE_BREAK_EN
      tie_flag <= 1'b0;
`endif
    end else begin
      lfsr <= {lfsr[14:0], lfsr_fb};
      // A running result is always allowed to finish its hold.
      if (over && st != S_RESULT) begin
        st      <= S_DONE;
        rw      <= 1'b0;
        wingame <= 1'b0;
        go_led  <= 1'b0;
        foul    <= 1'b0;
      end else begin
        case (st)
          S_IDLE: begin
            if (start) st <= S_RELEASE;
          end
          S_RELEASE: begin
            if (!bl && !br) begin
              st    <= S_WAIT;
              dly   <= dly_seed;
              presc <= '0;
            end
          end
          S_WAIT: begin
            // A press always beats the delay expiring.
            unique case (1'b1)
              both: st <= S_RELEASE;
              only_l: begin
                st      <= S_RESULT;
                rw      <= 1'b1;
                wingame <= 1'b1;
                foul    <= 1'b1;
                hold    <= HLD_W'(HOLD_CYC - 1);
              end
              only_r: begin
                st      <= S_RESULT;
                rw      <= 1'b0;
                wingame <= 1'b1;
                foul    <= 1'b1;
                hold    <= HLD_W'(HOLD_CYC - 1);
              end
              default: begin
                presc <= tick ? '0 : presc + 1'b1;
                if (dly == '0) begin
                  st     <= S_GO;
                  go_led <= 1'b1;
                end else if (tick) begin
                  dly <= dly - 1'b1;
                  if (dly == DLY_W'(1)) begin
                    st     <= S_GO;
                    go_led <= 1'b1;
                  end
                end
              end
            endcase
          end
          S_GO: begin
            unique case (1'b1)
              both: begin
                go_led <= 1'b0;
`ifdef TIE_BREAK_EN
                st       <= S_RESULT;
                rw       <= tie_flag;
                wingame  <= 1'b1;
                foul     <= 1'b0;
                hold     <= HLD_W'(HOLD_CYC - 1);
                tie_flag <= ~tie_flag;
`else
                st <= S_RELEASE;
`endif
              end
              only_l: begin
                st      <= S_RESULT;
                go_led  <= 1'b0;
                rw      <= 1'b0;
                wingame <= 1'b1;
                foul    <= 1'b0;
                hold    <= HLD_W'(HOLD_CYC - 1);
              end
              only_r: begin
                st      <= S_RESULT;
                go_led  <= 1'b0;
                rw      <= 1'b1;
                wingame <= 1'b1;
                foul    <= 1'b0;
                hold    <= HLD_W'(HOLD_CYC - 1);
              end
              default: ;
            endcase
          end
          S_RESULT: begin
            if (over) ovr_pend <= 1'b1;
            if (hold == '0) begin
              rw       <= 1'b0;
              wingame  <= 1'b0;
              foul     <= 1'b0;
              ovr_pend <= 1'b0;
              st       <= (over || ovr_pend) ? S_DONE : S_RELEASE;
            end else begin
              hold <= hold - 1'b1;
            end
          end
          S_DONE: ;
          default: st <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_round_referee.sv
// Scoreboard bench for round_referee: random rounds vs a spec-level model.
// Expected results are queued at press time and popped when wingame rises.
module tb_round_referee;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_l, btn_r, start, over;
  logic       rw, wingame, go_led, foul;
  logic [2:0] state;

  round_referee #(
    .TICK_DIV(2), .MIN_TICKS(3), .RAND_BITS(2),
    .HOLD_CYC(4), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst(rst), .btn_l(btn_l), .btn_r(btn_r),
    .start(start), .over(over), .rw(rw), .wingame(wingame),
    .go_led(go_led), .foul(foul), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic rw;
    logic foul;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   wait_checks = 0;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  // Reference LFSR: 16-bit Fibonacci, feedback is XOR of taps 16,14,13,11.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    int   taps [4];
    logic fb;
    taps = '{16, 14, 13, 11};
    fb = 1'b0;
    foreach (taps[i]) fb = fb ^ v[taps[i]-1];
    return {v[14:0], fb};
  endfunction

  logic [15:0] m_lfsr, m_prev;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_lfsr = 16'hACE1;
      m_prev = 16'hACE1;
    end else begin
      m_prev = m_lfsr;
      m_lfsr = lfsr_next(m_lfsr);
    end
  end

  // Monitor: WAIT length, result values, result hold length.
  logic [2:0] prev_st;
  logic       prev_wg;
  int         wcnt, exp_w, hcnt;
  exp_t       cur;
  always @(negedge clk) begin
    if (!rst) begin
      prev_st = 3'd0;
      prev_wg = 1'b0;
      wcnt = 0;
      hcnt = 0;
    end else begin
      if (state == 3'd1 && prev_st != 3'd1) begin
        exp_w = 2 * (3 + int'(m_prev[1:0]));
        wcnt = 0;
      end
      if (state == 3'd1) wcnt++;
      if (prev_st == 3'd1 && state == 3'd2) begin
        chk("wait_len", wcnt, exp_w);
        wait_checks++;
      end
      if (wingame && !prev_wg) begin
        if (q.size() == 0) begin
          chk("unexpected_result", 1, 0);
          cur = '{rw: rw, foul: foul};
        end else begin
          cur = q.pop_front();
          chk("result_rw", rw, cur.rw);
          chk("result_foul", foul, cur.foul);
        end
        hcnt = 0;
      end else if (wingame) begin
        chk("hold_rw", rw, cur.rw);
        chk("hold_foul", foul, cur.foul);
      end
      if (wingame) hcnt++;
      if (!wingame && prev_wg) chk("hold_len", hcnt, 4);
      prev_st = state;
      prev_wg = wingame;
    end
  end

  task automatic wait_state(input logic [2:0] s);
    bit ok;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (state == s) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("wait_state_timeout", int'(state), int'(s));
  endtask

  task automatic expect_result(input string nm, output bit go_seen);
    int n;
    n = 0;
    go_seen = 0;
    do begin
      @(negedge clk);
      n++;
      go_seen |= go_led;
    end while (!wingame && n < 20);
    chk(nm, n, 3);
  endtask

  task automatic expect_void(input string nm, input logic [2:0] from);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (state == from && n < 20);
    chk(nm, int'(state), 4);
  endtask

`ifdef TIE_BREAK_EN
  logic tie_flag_m = 1'b0;
`endif

  task automatic play(input int kind);
    bit g;
    case (kind)
      0, 1: begin
        wait_state(3'd2);
        chk("go_led_in_go", go_led, 1);
        btn_r = (kind == 0);
        btn_l = (kind == 1);
        q.push_back('{rw: (kind == 0), foul: 1'b0});
        expect_result("go_latency", g);
        chk("go_led_in_result", go_led, 0);
      end
      2, 3: begin
        wait_state(3'd1);
        btn_l = (kind == 2);
        btn_r = (kind == 3);
        q.push_back('{rw: (kind == 2), foul: 1'b1});
        expect_result("false_latency", g);
        chk("false_go_led", g, 0);
      end
      4: begin
        wait_state(3'd1);
        btn_l = 1'b1;
        btn_r = 1'b1;
        expect_void("wait_void", 3'd1);
      end
      default: begin
        wait_state(3'd2);
        btn_l = 1'b1;
        btn_r = 1'b1;
`ifdef TIE_BREAK_EN
        q.push_back('{rw: tie_flag_m, foul: 1'b0});
        tie_flag_m = ~tie_flag_m;
        expect_result("tie_latency", g);
`else
        expect_void("tie_void", 3'd2);
`endif
      end
    endcase
    btn_l = 1'b0;
    btn_r = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit g;
    int n;
    bit seen;
    rst = 1'b0;
    btn_l = 1'b0;
    btn_r = 1'b0;
    start = 1'b0;
    over = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", int'(state), 0);
    chk("rst_wingame", wingame, 0);
    chk("rst_rw", rw, 0);
    chk("rst_go_led", go_led, 0);
    chk("rst_foul", foul, 0);
    rst = 1'b1;
    @(negedge clk);
    start = 1'b1;
    wait_state(3'd1);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midwait_rst_state", int'(state), 0);
    chk("midwait_rst_go_led", go_led, 0);
    chk("midwait_rst_wingame", wingame, 0);
    chk("midwait_rst_rw", rw, 0);
    chk("midwait_rst_lfsr", int'(dut.lfsr), 16'hACE1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_after_rst", int'(state), 0);
    start = 1'b1;
    wait_state(3'd1);
    start = 1'b0;

    for (int i = 0; i < 30; i++)
      play((i < 6) ? i : int'($urandom_range(0, 5)));

    wait_state(3'd2);
    btn_r = 1'b1;
    q.push_back('{rw: 1'b1, foul: 1'b0});
    expect_result("over_latency", g);
    over = 1'b1;
    btn_r = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (wingame && n < 20);
    chk("over_done_state", int'(state), 5);
    seen = 0;
    btn_l = 1'b1;
    repeat (12) begin
      @(negedge clk);
      seen |= wingame | go_led | foul;
    end
    btn_l = 1'b0;
    chk("done_no_output", seen, 0);
    chk("done_stays", int'(state), 5);

    rst = 1'b0;
    over = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_over_done", int'(state), 5);
    start = 1'b0;
    over = 1'b0;
    @(negedge clk);

    chk("wait_rounds_ge8", int'(wait_checks >= 8), 1);
    chk("sb_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
